// File: rtl/wb_spi_master.sv
// Wishbone-classic SPI master: one byte per transfer, MSB first, full duplex,
// programmable CPOL/CPHA and SCLK divider, software-owned chip select.
module wb_spi_master #(
    parameter int ADDR_W = 5,
    parameter int DIV_W  = 8
) (
    input  logic              wb_clk,
    input  logic              wb_rst_n,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic              wb_we_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              o_spi_sclk,
    output logic              o_spi_cs_n,
    output logic              o_spi_mosi,
    input  logic              i_spi_miso,
    output logic              o_irq
);

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_CLKDIV = 3'd1;
    localparam logic [2:0] REG_TXDATA = 3'd2;
    localparam logic [2:0] REG_RXDATA = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    typedef enum logic {S_IDLE, S_XFER} state_t;
    state_t state_reg, state_next;

    logic             ack_reg;
    logic [31:0]      dat_o_reg;
    logic [4:0]       ctrl_reg;
    logic [DIV_W-1:0] clkdiv_reg;
    logic [7:0]       rxdata_reg;
    logic             rx_valid_reg;
    logic             wcol_reg;
    logic [7:0]       shreg_reg;
    logic             miso_bit_reg;
    logic             mosi_reg;
    logic             sclk_reg;
    logic             mode_cpol_reg;
    logic             mode_cpha_reg;
    logic [DIV_W-1:0] div_cnt_reg;
    logic [3:0]       edge_cnt_reg;

    logic        addr_ok;
    logic [2:0]  reg_sel;
    logic        access, wr_en, rd_en;
    logic        tx_wr, start, status_wr, rx_rd;
    logic        busy, abort, edge_tick, last_edge, done;
    logic        shift_in;
    logic [7:0]  rx_byte;
    logic [31:0] rd_data;
    logic        unused_bits;

    // Address bits above the register window must be zero for a hit.
    if (ADDR_W > 5) begin : g_hi_decode
        assign addr_ok = (wb_adr_i[ADDR_W-1:5] == '0);
    end else begin : g_no_hi_decode
        assign addr_ok = 1'b1;
    end

    assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i};

    assign reg_sel   = wb_adr_i[4:2];
    assign access    = wb_cyc_i & wb_stb_i & ~ack_reg;
    assign wr_en     = access & wb_we_i;
    assign rd_en     = access & ~wb_we_i;
    assign tx_wr     = wr_en & addr_ok & (reg_sel == REG_TXDATA);
    assign status_wr = wr_en & addr_ok & (reg_sel == REG_STATUS);
    assign rx_rd     = rd_en & addr_ok & (reg_sel == REG_RXDATA);
    assign busy      = (state_reg == S_XFER);
    assign start     = tx_wr & ~busy & ctrl_reg[0];
    assign abort     = busy & ~ctrl_reg[0];
    assign edge_tick = busy & (div_cnt_reg >= clkdiv_reg);
    assign last_edge = edge_tick & (edge_cnt_reg == 4'd15);
    assign done      = last_edge & ~abort;

    // CPHA=1 samples straight off the pin on the shifting edge; CPHA=0 uses
    // the bit captured on the preceding leading edge.
    assign shift_in = mode_cpha_reg ? i_spi_miso : miso_bit_reg;
    assign rx_byte  = {shreg_reg[6:0], shift_in};

    always_comb begin
        rd_data = '0;
        if (addr_ok) begin
            case (reg_sel)
                REG_CTRL:   rd_data[4:0]       = ctrl_reg;
                REG_CLKDIV: rd_data[DIV_W-1:0] = clkdiv_reg;
                REG_RXDATA: rd_data[7:0]       = rxdata_reg;
                REG_STATUS: rd_data[2:0]       = {wcol_reg, rx_valid_reg, busy};
                default:    rd_data            = '0;
            endcase
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            ack_reg      <= 1'b0;
            dat_o_reg    <= '0;
            ctrl_reg     <= '0;
            clkdiv_reg   <= '0;
            rxdata_reg   <= '0;
            rx_valid_reg <= 1'b0;
            wcol_reg     <= 1'b0;
        end else begin
            ack_reg   <= access;
            dat_o_reg <= rd_en ? rd_data : '0;
            if (wr_en && addr_ok && reg_sel == REG_CTRL)
                ctrl_reg <= wb_dat_i[4:0];
            if (wr_en && addr_ok && reg_sel == REG_CLKDIV)
                clkdiv_reg <= wb_dat_i[DIV_W-1:0];
            if (tx_wr && !start)
                wcol_reg <= 1'b1;
            else if (status_wr && wb_dat_i[2])
                wcol_reg <= 1'b0;
            // A completing byte beats a simultaneous RXDATA read.
            if (done) begin
                rxdata_reg   <= rx_byte;
                rx_valid_reg <= 1'b1;
            end else if (rx_rd) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) state_reg <= S_IDLE;
        else           state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_XFER;
            S_XFER:  if (abort || last_edge) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            shreg_reg     <= '0;
            miso_bit_reg  <= 1'b0;
            mosi_reg      <= 1'b0;
            sclk_reg      <= 1'b0;
            mode_cpol_reg <= 1'b0;
            mode_cpha_reg <= 1'b0;
            div_cnt_reg   <= '0;
            edge_cnt_reg  <= '0;
        end else if (!busy) begin
            sclk_reg <= ctrl_reg[1];
            if (start) begin
                mode_cpol_reg <= ctrl_reg[1];
                mode_cpha_reg <= ctrl_reg[2];
                shreg_reg     <= wb_dat_i[7:0];
                div_cnt_reg   <= '0;
                edge_cnt_reg  <= '0;
                if (!ctrl_reg[2]) mosi_reg <= wb_dat_i[7];
            end
        end else if (abort) begin
            sclk_reg <= mode_cpol_reg;
        end else if (edge_tick) begin
            div_cnt_reg  <= '0;
            edge_cnt_reg <= edge_cnt_reg + 4'd1;
            sclk_reg     <= ~sclk_reg;
            if (!edge_cnt_reg[0]) begin
                // odd edge: leading
                if (mode_cpha_reg) mosi_reg     <= shreg_reg[7];
                else               miso_bit_reg <= i_spi_miso;
            end else begin
                shreg_reg <= rx_byte;
                if (!mode_cpha_reg) mosi_reg <= shreg_reg[6];
            end
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    assign wb_ack_o   = ack_reg;
    assign wb_dat_o   = dat_o_reg;
    assign o_spi_sclk = sclk_reg;
    assign o_spi_cs_n = ~ctrl_reg[3];
    assign o_spi_mosi = mosi_reg;
    assign o_irq      = rx_valid_reg & ctrl_reg[4];

endmodule

// File: tb/tb_wb_spi_master.sv
// Bench for wb_spi_master: fixed-mode and randomized byte transfers checked
// against a byte-level model of the SPI exchange, plus bus and control corners.
module tb_wb_spi_master;

    logic        wb_clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        wb_rst_n = 1'b1;
    logic [4:0]  wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic        wb_we_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        o_spi_sclk;
    logic        o_spi_cs_n;
    logic        o_spi_mosi;
    logic        i_spi_miso;
    logic        o_irq;

    int total = 0;
    int bad = 0;
    int miso_sel = 0;   // 0 loopback, 1 inverted loopback, 2 tied 0, 3 tied 1

    localparam logic [4:0] A_CTRL = 5'h00, A_CLKDIV = 5'h04, A_TX = 5'h08,
                           A_RX = 5'h0C, A_STATUS = 5'h10, A_UNMAPPED = 5'h1C;

    assign i_spi_miso = (miso_sel == 0) ? o_spi_mosi :
                        (miso_sel == 1) ? ~o_spi_mosi : (miso_sel == 3);

    wb_spi_master #(.ADDR_W(5), .DIV_W(8)) dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .wb_adr_i(wb_adr_i),
        .wb_dat_i(wb_dat_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i),
        .wb_stb_i(wb_stb_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .o_spi_sclk(o_spi_sclk), .o_spi_cs_n(o_spi_cs_n),
        .o_spi_mosi(o_spi_mosi), .i_spi_miso(i_spi_miso), .o_irq(o_irq)
    );

    initial forever begin
        #5;
        if (clk_en) wb_clk = ~wb_clk;
    end

    // Every SCLK transition records the MOSI level present at that edge.
    logic edge_mosi[$];
    always @(o_spi_sclk) edge_mosi.push_back(o_spi_mosi);

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        int n;
        @(negedge wb_clk);
        while (wb_ack_o) @(negedge wb_clk);
        wb_adr_i = a; wb_dat_i = d; wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        n = 0;
        do begin @(posedge wb_clk); #1; n++; end while (!wb_ack_o && n < 8);
        total++;
        if (!(wb_ack_o === 1'b1 && n == 1)) begin
            bad++;
            $display("FAIL wr_ack addr=%h ack=%b after %0d cycles, want ack=1 after 1", a, wb_ack_o, n);
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic wb_read(input logic [4:0] a, output logic [31:0] d);
        int n;
        @(negedge wb_clk);
        while (wb_ack_o) @(negedge wb_clk);
        wb_adr_i = a; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        n = 0;
        do begin @(posedge wb_clk); #1; n++; end while (!wb_ack_o && n < 8);
        total++;
        if (!(wb_ack_o === 1'b1 && n == 1)) begin
            bad++;
            $display("FAIL rd_ack addr=%h ack=%b after %0d cycles, want ack=1 after 1", a, wb_ack_o, n);
        end
        d = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        #2 wb_rst_n = 1'b0;
        #1;
        total++;
        if ({o_spi_sclk, o_spi_cs_n, o_spi_mosi, wb_ack_o, o_irq} !== 5'b01000) begin
            bad++;
            $display("FAIL reset_pins sclk,cs_n,mosi,ack,irq=%b want 01000",
                     {o_spi_sclk, o_spi_cs_n, o_spi_mosi, wb_ack_o, o_irq});
        end
        clk_en = 1'b1;
        repeat (3) @(negedge wb_clk);
        wb_rst_n = 1'b1;
        wb_read(A_CTRL, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL reset_ctrl got=%h want=0", d); end
        wb_read(A_CLKDIV, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL reset_clkdiv got=%h want=0", d); end
        wb_read(A_STATUS, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL reset_status got=%h want=0", d); end
        wb_write(A_UNMAPPED, 32'hFFFF_FFFF);
        wb_read(A_UNMAPPED, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL unmapped_read got=%h want=0", d); end
        wb_read(A_CTRL, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL unmapped_write_ctrl got=%h want=0", d); end
        $display("reset: pins and registers inspected");
    endtask

    // One full transfer, checked against the byte-level model: MOSI carries tx
    // MSB first on the sampling edges, 16 SCLK edges, 16*(div+1) cycles, and
    // RXDATA equals whatever the MISO source made of the transmitted bits.
    task automatic test_xfer(input logic [7:0] tx, input logic cpol, input logic cpha,
                             input logic [7:0] div, input int msel);
        logic [31:0] d;
        logic [7:0]  exp_rx, got_mosi;
        int base, lat;
        miso_sel = msel;
        wb_write(A_CTRL, {27'd0, 1'b1, 1'b1, cpha, cpol, 1'b1});
        wb_write(A_CLKDIV, {24'd0, div});
        repeat (3) @(posedge wb_clk);
        #1;
        total++;
        if ({o_spi_sclk, o_spi_cs_n} !== {cpol, 1'b0}) begin
            bad++;
            $display("FAIL idle_pins sclk,cs_n=%b%b want %b0", o_spi_sclk, o_spi_cs_n, cpol);
        end
        base = edge_mosi.size();
        wb_write(A_TX, {24'd0, tx});
        lat = 0;
        do begin @(posedge wb_clk); #1; lat++; end while (!o_irq && lat < 5000);
        total++;
        if (lat != 16 * (int'(div) + 1)) begin
            bad++;
            $display("FAIL xfer_length got=%0d cycles want=%0d", lat, 16 * (int'(div) + 1));
        end
        total++;
        if (edge_mosi.size() - base != 16 || o_spi_sclk !== cpol) begin
            bad++;
            $display("FAIL sclk_edges got=%0d end_sclk=%b want 16 edges end_sclk=%b",
                     edge_mosi.size() - base, o_spi_sclk, cpol);
        end
        got_mosi = '0;
        for (int i = 0; i < 8; i++) begin
            int idx;
            idx = base + 2 * i + (cpha ? 1 : 0);
            if (idx < edge_mosi.size()) got_mosi[7 - i] = edge_mosi[idx];
        end
        total++;
        if (got_mosi !== tx) begin
            bad++;
            $display("FAIL mosi_bits got=%h want=%h", got_mosi, tx);
        end
        case (msel)
            0:       exp_rx = tx;
            1:       exp_rx = ~tx;
            2:       exp_rx = 8'h00;
            default: exp_rx = 8'hFF;
        endcase
        wb_read(A_STATUS, d);
        total++;
        if (d !== 32'h2) begin bad++; $display("FAIL status_done got=%h want=2", d); end
        wb_read(A_RX, d);
        total++;
        if (d !== {24'd0, exp_rx}) begin bad++; $display("FAIL rxdata got=%h want=%h", d, exp_rx); end
        wb_read(A_STATUS, d);
        total++;
        if (d !== 32'h0 || o_irq !== 1'b0) begin
            bad++;
            $display("FAIL rx_clear status=%h irq=%b want status=0 irq=0", d, o_irq);
        end
        $display("xfer tx=%h cpol=%b cpha=%b div=%0d miso=%0d rx_exp=%h cycles=%0d",
                 tx, cpol, cpha, div, msel, exp_rx, lat);
    endtask

    task automatic test_random_xfers();
        for (int k = 0; k < 8; k++) begin
            test_xfer(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_wcol();
        logic [31:0] d;
        logic [7:0]  got_mosi;
        int base, lat;
        miso_sel = 0;
        wb_write(A_CTRL, 32'h19);
        wb_write(A_CLKDIV, 32'h3);
        repeat (3) @(posedge wb_clk);
        base = edge_mosi.size();
        wb_write(A_TX, 32'h11);
        wb_write(A_TX, 32'h22);
        wb_read(A_STATUS, d);
        total++;
        if (d !== 32'h5) begin bad++; $display("FAIL wcol_busy status=%h want=5", d); end
        lat = 0;
        do begin @(posedge wb_clk); #1; lat++; end while (!o_irq && lat < 5000);
        total++;
        if (o_irq !== 1'b1) begin bad++; $display("FAIL wcol_done irq=%b want=1", o_irq); end
        wb_read(A_RX, d);
        total++;
        if (d !== 32'h11) begin bad++; $display("FAIL wcol_rx got=%h want=11", d); end
        got_mosi = '0;
        for (int i = 0; i < 8; i++)
            if (base + 2 * i < edge_mosi.size()) got_mosi[7 - i] = edge_mosi[base + 2 * i];
        total++;
        if (got_mosi !== 8'h11) begin bad++; $display("FAIL wcol_mosi got=%h want=11", got_mosi); end
        wb_write(A_STATUS, 32'h4);
        wb_read(A_STATUS, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL wcol_clear status=%h want=0", d); end
        wb_write(A_CTRL, 32'h18);
        wb_write(A_TX, 32'h33);
        wb_read(A_STATUS, d);
        total++;
        if (d !== 32'h4) begin bad++; $display("FAIL wcol_disabled status=%h want=4", d); end
        wb_write(A_STATUS, 32'h4);
        $display("wcol: tx 11 then 22 while busy, then tx 33 with EN clear");
    endtask

    task automatic test_abort();
        logic [31:0] d;
        int base, n, edges_after;
        miso_sel = 0;
        wb_write(A_CTRL, 32'h19);
        wb_write(A_CLKDIV, 32'h2);
        repeat (3) @(posedge wb_clk);
        base = edge_mosi.size();
        wb_write(A_TX, 32'hC3);
        n = 0;
        while (edge_mosi.size() - base < 3 && n < 200) begin
            @(posedge wb_clk); #1; n++;
        end
        total++;
        if (edge_mosi.size() - base != 3) begin
            bad++;
            $display("FAIL abort_wait edges=%0d want=3", edge_mosi.size() - base);
        end
        wb_write(A_CTRL, 32'h18);
        @(posedge wb_clk); #1;
        total++;
        if (o_spi_sclk !== 1'b0) begin bad++; $display("FAIL abort_sclk got=%b want=0", o_spi_sclk); end
        edges_after = edge_mosi.size() - base;
        repeat (40) @(posedge wb_clk);
        #1;
        total++;
        if (edge_mosi.size() - base != edges_after) begin
            bad++;
            $display("FAIL abort_quiet edges=%0d want=%0d", edge_mosi.size() - base, edges_after);
        end
        wb_read(A_STATUS, d);
        total++;
        if (d !== 32'h0 || o_irq !== 1'b0) begin
            bad++;
            $display("FAIL abort_status status=%h irq=%b want status=0 irq=0", d, o_irq);
        end
        $display("abort: EN cleared after edge 3, edges seen=%0d", edges_after);
    endtask

    task automatic test_back_to_back();
        logic [7:0] r;
        logic       exp_ack;
        r = 8'($urandom_range(1, 255));
        wb_write(A_CLKDIV, {24'd0, r});
        @(negedge wb_clk);
        while (wb_ack_o) @(negedge wb_clk);
        wb_adr_i = A_CLKDIV; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        total++;
        if (wb_ack_o !== 1'b0) begin bad++; $display("FAIL b2b_ack0 got=%b want=0", wb_ack_o); end
        for (int i = 1; i <= 4; i++) begin
            @(posedge wb_clk); #1;
            exp_ack = (i % 2 == 1);
            total++;
            if (wb_ack_o !== exp_ack || (exp_ack && wb_dat_o !== {24'd0, r})) begin
                bad++;
                $display("FAIL b2b_cycle%0d ack=%b data=%h want ack=%b data=%h",
                         i, wb_ack_o, wb_dat_o, exp_ack, r);
            end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        $display("b2b: held read of CLKDIV=%h", r);
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        miso_sel = 3;
        wb_write(A_CTRL, 32'h1B);
        wb_write(A_CLKDIV, 32'h7);
        wb_write(A_TX, 32'h5A);
        repeat (20) @(posedge wb_clk);
        #3 wb_rst_n = 1'b0;
        #1;
        total++;
        if ({o_spi_sclk, o_spi_cs_n, o_spi_mosi, wb_ack_o, o_irq} !== 5'b01000 || wb_dat_o !== 32'h0) begin
            bad++;
            $display("FAIL async_reset sclk,cs_n,mosi,ack,irq=%b dat=%h want 01000 dat=0",
                     {o_spi_sclk, o_spi_cs_n, o_spi_mosi, wb_ack_o, o_irq}, wb_dat_o);
        end
        repeat (2) @(negedge wb_clk);
        wb_rst_n = 1'b1;
        wb_read(A_STATUS, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL async_reset_status got=%h want=0", d); end
        wb_read(A_CTRL, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL async_reset_ctrl got=%h want=0", d); end
        $display("async reset: asserted mid-transfer");
    endtask

    initial begin
        test_reset();
        test_xfer(8'hA5, 1'b0, 1'b0, 8'd1, 0);
        test_xfer(8'h3C, 1'b1, 1'b1, 8'd3, 3);
        test_xfer(8'h81, 1'b0, 1'b1, 8'd0, 1);
        test_random_xfers();
        test_wcol();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
